glyph_sprite_writer: RTL and testbench

// - Write-side counterpart of the score digit glyph ROMs: a writable 11x16, 3-bit RGB glyph store.
// - Loads pixels from a valid/ready stream in raster order (col fastest, then row).
// - Serves the same combinational row/col -> rgb read port the score renderer already uses.
// - Lets the game controller re-skin score digits at runtime instead of relying on $readmemb images.

---
 rtl/glyph_sprite_writer_pkg.sv | 16 +
 rtl/glyph_ram.sv | 27 ++
 rtl/glyph_sprite_writer.sv | 144 ++++++++++++++
 tb/tb_glyph_sprite_writer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/glyph_sprite_writer_pkg.sv
// Shared glyph geometry and writer state encoding for the writable score-digit glyph store.
package glyph_sprite_writer_pkg;

    localparam int unsigned GLYPH_W        = 11;
    localparam int unsigned GLYPH_H        = 16;
    localparam int unsigned GLYPH_PIX_BITS = 3;
    localparam int unsigned GLYPH_DEPTH    = GLYPH_W * GLYPH_H;
    localparam int unsigned GLYPH_AW       = $clog2(GLYPH_DEPTH);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } glyph_state_e;

endpackage

// File: rtl/glyph_ram.sv
// Pixel store: one synchronous write port, one asynchronous read port.
module glyph_ram
    import glyph_sprite_writer_pkg::*;
#(
    parameter int unsigned DEPTH    = GLYPH_DEPTH,
    parameter int unsigned AW       = GLYPH_AW,
    parameter int unsigned PIX_BITS = GLYPH_PIX_BITS
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [PIX_BITS-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [PIX_BITS-1:0] rdata
);

    logic [PIX_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/glyph_sprite_writer.sv
// Writable 11x16 RGB glyph: clears itself after reset, loads from a raster-order stream,
// and serves the same combinational row/col read port as the fixed glyph ROMs.
module glyph_sprite_writer
    import glyph_sprite_writer_pkg::*;
#(
    parameter int unsigned WIDTH    = GLYPH_W,
    parameter int unsigned HEIGHT   = GLYPH_H,
    parameter int unsigned PIX_BITS = GLYPH_PIX_BITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                in_valid,
    input  logic [PIX_BITS-1:0] in_pixel,
    input  logic                in_last,
    output logic                in_ready,
    output logic                busy,
    output logic                done,
    output logic                error,
    input  logic [9:0]          row,
    input  logic [9:0]          col,
    output logic [PIX_BITS-1:0] rgb
);

    localparam int unsigned DEPTH = WIDTH * HEIGHT;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = $clog2(WIDTH);
    localparam int unsigned RW    = $clog2(HEIGHT);

    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    glyph_state_e      state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [AW-1:0]     clr_addr_q, clr_addr_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [PIX_BITS-1:0] ram_wdata;
    logic [AW-1:0]     cursor_addr;
    logic              final_pix;
    logic              rd_in_range;
    logic [AW-1:0]     rd_addr;
    logic [PIX_BITS-1:0] rd_data;

    assign cursor_addr = AW'(row_q) * AW'(WIDTH) + AW'(col_q);
    assign final_pix   = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        clr_addr_d = clr_addr_q;
        done_d     = 1'b0;
        error_d    = error_q;
        ram_we     = 1'b0;
        ram_waddr  = cursor_addr;
        ram_wdata  = in_pixel;

        unique case (state_q)
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = clr_addr_q;
                ram_wdata = '0;
                if (clr_addr_q == ADDR_LAST) begin
                    clr_addr_d = '0;
                    state_d    = ST_IDLE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    row_d   = '0;
                    col_d   = '0;
                    error_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    ram_we = 1'b1;
                    if (final_pix || in_last) begin
                        // Short and long streams both end here; only an exact match is done.
                        state_d = ST_IDLE;
                        done_d  = final_pix && in_last;
                        error_d = final_pix ^ in_last;
                    end else if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_CLEAR;
            row_q      <= '0;
            col_q      <= '0;
            clr_addr_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            clr_addr_q <= clr_addr_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign rd_in_range = (col < 10'(WIDTH)) && (row < 10'(HEIGHT));
    assign rd_addr     = rd_in_range ? (AW'(row) * AW'(WIDTH) + AW'(col)) : '0;

    glyph_ram #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .PIX_BITS (PIX_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we && !reset),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign rgb      = rd_in_range ? rd_data : '0;
    assign in_ready = (state_q == ST_LOAD);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_glyph_sprite_writer.sv
// Scoreboard bench for glyph_sprite_writer: stream loads against a raster-array model.
module tb_glyph_sprite_writer;

    localparam int W = 11;
    localparam int H = 16;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_pixel = '0;
    logic       in_last = 1'b0;
    logic       in_ready, busy, done, error;
    logic [9:0] row = '0;
    logic [9:0] col = '0;
    logic [2:0] rgb;

    glyph_sprite_writer dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_pixel (in_pixel),
        .in_last  (in_last),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .row      (row),
        .col      (col),
        .rgb      (rgb)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int model [H][W];

    typedef struct { int done; int err; int acc; } load_exp_t;
    typedef struct { int r; int c; int v; } rd_exp_t;
    load_exp_t exp_q[$];
    rd_exp_t   rd_q[$];
    load_exp_t le;
    rd_exp_t   re;
    event      rd_ev;
    int        acc_cnt = 0;
    int        done_seen = 0;
    int        done_expected = 0;
    bit        prev_rdy = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: accepted beats, load termination, done pulses
    always @(posedge clk) begin
        if (in_valid === 1'b1 && in_ready === 1'b1) acc_cnt++;
    end

    always @(negedge clk) begin
        if (prev_rdy && in_ready !== 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL load_end: got unexpected end of load, expected none");
            end else begin
                le = exp_q.pop_front();
                check("load_done", int'(done), le.done);
                check("load_error", int'(error), le.err);
                check("load_accepts", acc_cnt, le.acc);
            end
            acc_cnt = 0;
        end
        if (done === 1'b1) done_seen++;
        prev_rdy = (in_ready === 1'b1);
    end

    always begin
        @(rd_ev);
        #1;
        if (rd_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rgb_read: got read with no expectation, expected queued read");
        end else begin
            re = rd_q.pop_front();
            check($sformatf("rgb(%0d,%0d)", re.r, re.c), int'(rgb), re.v);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rd(input int r, input int c, input int v);
        row = 10'(r);
        col = 10'(c);
        rd_q.push_back('{r, c, v});
        -> rd_ev;
        #2;
    endtask

    task automatic sweep();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                chk_rd(r, c, model[r][c]);
    endtask

    task automatic reset_and_clear(input int start_at);
        int n;
        int rdy_seen;
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        tick();
        tick();
        check("reset_busy", int'(busy), 1);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_done", int'(done), 0);
        check("reset_error", int'(error), 0);
        reset = 1'b0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                model[r][c] = 0;
        n = 0;
        rdy_seen = 0;
        while (n < 400) begin
            tick();
            n++;
            if (in_ready === 1'b1) rdy_seen++;
            start = (n == start_at);
            if (busy === 1'b0) break;
        end
        start = 1'b0;
        check("clear_cycles", n, N);
        check("clear_in_ready_seen", rdy_seen, 0);
        check("clear_error", int'(error), 0);
        tick();
        tick();
        check("idle_after_clear", int'(in_ready), 0);
    endtask

    task automatic run_load(input int n, input int last_idx, input int pct, input bit rnd,
                            input bit start_on_final, input int abort_after);
        int px [200];
        int ndrive, nacc, t0, waitc, seen;
        bit acc;
        load_exp_t e;
        for (int k = 0; k < n; k++)
            px[k] = rnd ? int'($urandom_range(7)) : ((k / W) + (k % W)) % 8;
        ndrive = (last_idx >= 0) ? last_idx + 1 : n;
        if (abort_after >= 0) ndrive = abort_after;
        nacc = (ndrive > N) ? N : ndrive;
        for (int k = 0; k < nacc; k++)
            model[k / W][k % W] = px[k];
        e.done = (abort_after < 0 && last_idx == N - 1) ? 1 : 0;
        e.err  = (abort_after < 0 && e.done == 0) ? 1 : 0;
        e.acc  = nacc;
        exp_q.push_back(e);
        done_expected += e.done;

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_clears_error", int'(error), 0);
        check("start_enters_load", int'(in_ready), 1);
        t0 = cyc;
        for (int k = 0; k < ndrive; k++) begin
            if (k >= N) begin
                in_valid = 1'b1;
                in_pixel = 3'(px[k]);
                in_last  = 1'b0;
                seen = 0;
                repeat (4) begin
                    @(negedge clk);
                    if (in_ready === 1'b1) seen++;
                end
                check("extra_beat_ready", seen, 0);
                tick();
                in_valid = 1'b0;
                break;
            end
            if (pct > 0) begin
                while (int'($urandom_range(99)) < pct) tick();
            end
            in_valid = 1'b1;
            in_pixel = 3'(px[k]);
            in_last  = (k == last_idx);
            start    = start_on_final && (k == N - 1);
            waitc = 0;
            do begin
                @(negedge clk);
                acc = (in_ready === 1'b1);
                tick();
                waitc++;
            end while (!acc && waitc < 200);
            in_valid = 1'b0;
            in_last  = 1'b0;
            start    = 1'b0;
            if (!acc) begin
                vectors++;
                miscompares++;
                $display("FAIL beat_accept: got no accept in 200 cycles at beat %0d, expected accept", k);
                break;
            end
        end
        if (pct == 0 && n == N && last_idx == N - 1 && abort_after < 0)
            check("sustained_cycles", cyc - t0, N);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_and_clear(50);
        sweep();
        chk_rd(0, 11, 0);

        run_load(N, N - 1, 0, 1'b0, 1'b1, -1);
        tick();
        tick();
        check("start_at_exit_ignored", int'(in_ready), 0);
        check("full_load_error", int'(error), 0);
        chk_rd(5, 3, 0);
        chk_rd(15, 10, 1);
        sweep();

        run_load(N, N - 1, 50, 1'b0, 1'b0, -1);
        sweep();
        run_load(N, N - 1, 50, 1'b1, 1'b0, -1);
        sweep();

        run_load(N, 40, 30, 1'b1, 1'b0, -1);
        repeat (5) tick();
        check("short_error_sticky", int'(error), 1);
        check("short_stays_idle", int'(busy), 0);
        chk_rd(3, 7, model[3][7]);
        chk_rd(3, 8, model[3][8]);
        sweep();

        run_load(N + 1, -1, 20, 1'b1, 1'b0, -1);
        repeat (3) tick();
        check("long_error_sticky", int'(error), 1);
        sweep();

        chk_rd(0, 11, 0);
        chk_rd(16, 0, 0);
        chk_rd(0, 1023, 0);
        chk_rd(1023, 0, 0);
        chk_rd(1023, 1023, 0);

        run_load(N, -1, 0, 1'b1, 1'b0, 30);
        reset_and_clear(-1);
        sweep();

        check("done_pulses", done_seen, done_expected);
        check("load_queue_drained", exp_q.size(), 0);
        #20;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
